nco_pdm_synth: RTL and testbench

Parametrised numerically controlled oscillator with selectable waveform and sigma-delta PDM output. It extends the existing 16-bit, first-order NCO/PDM tile with:
- configurable accumulator and sample widths;
- byte-serial frequency loading with phase-continuous commit;
- square, sawtooth and triangle modes;
- a first- or second-order modulator.

It drives a single-bit output pin through an external RC filter.

---
 rtl/nco_pdm_synth_if.sv | 10 +
 rtl/nco_pdm_synth.sv | 173 +++++++++++++++++
 tb/tb_nco_pdm_synth.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/nco_pdm_synth_if.sv
// Byte-serial frequency-load channel of the NCO/PDM tile.
// The master supplies bytes; the slave (the NCO) returns backpressure.
interface nco_pdm_synth_if;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;

    modport master (output ld_valid, output ld_data, input ld_ready);
    modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/nco_pdm_synth.sv
// Numerically controlled oscillator with square/saw/triangle shaping and a
// first- or second-order sigma-delta modulator driving a single PDM pin.
module nco_pdm_synth #(
    parameter int ACC_W  = 24,
    parameter int FREQ_W = 16,
    parameter int OUT_W  = 8,
    parameter int ORDER  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    nco_pdm_synth_if.slave        ld,
    input  logic [1:0]            mode,
    output logic                  pdm_out,
    output logic                  sync,
    output logic                  pending
);
    typedef enum logic [1:0] {MODE_SQUARE, MODE_SAW, MODE_TRI, MODE_OFF} mode_e;

    localparam int NB    = FREQ_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    logic [CNT_W-1:0]  byte_cnt;
    logic [FREQ_W-1:0] shadow;
    logic [FREQ_W-1:0] freq;
    logic [ACC_W-1:0]  acc_p0;
    logic [ACC_W:0]    acc_sum;
    logic              wrap_p0;
    logic              carry, accept, commit, run;

    assign ld.ld_ready = ~pending;
    assign accept      = ld.ld_valid & ~pending;
    assign run         = (mode != MODE_OFF);
    assign acc_sum     = {1'b0, acc_p0} + {{(ACC_W + 1 - FREQ_W){1'b0}}, freq};
    assign carry       = acc_sum[ACC_W];
    // The new word lands on a wrap so the output phase stays continuous;
    // a frozen or stopped oscillator has no phase to protect.
    assign commit      = pending & (carry | (freq == '0) | ~run);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            shadow   <= '0;
            freq     <= '0;
            pending  <= 1'b0;
        end else begin
            if (accept) begin
                shadow[{byte_cnt, 3'b000} +: 8] <= ld.ld_data;
                if (byte_cnt == CNT_W'(NB - 1)) begin
                    byte_cnt <= '0;
                    pending  <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
            if (commit) begin
                freq    <= shadow;
                pending <= 1'b0;
            end
        end
    end

    // Stage p0: phase accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0  <= '0;
            wrap_p0 <= 1'b0;
        end else if (run) begin
            acc_p0  <= acc_sum[ACC_W-1:0];
            wrap_p0 <= carry;
        end else begin
            wrap_p0 <= 1'b0;
        end
    end

    logic [OUT_W-1:0] p, t, s_nxt;
    logic [OUT_W-1:0] s_p1;
    logic             q_p1;
    logic [1:0]       mode_p1;

    assign p = acc_p0[ACC_W-1 -: OUT_W];
    assign t = {p[OUT_W-2:0], 1'b0};

    always_comb begin
        s_nxt = p;
        if (mode == MODE_TRI)
            s_nxt = p[OUT_W-1] ? ~t : t;
    end

    // Stage p1: waveform sample; mode and sync travel with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_p1    <= '0;
            q_p1    <= 1'b0;
            mode_p1 <= '0;
            sync    <= 1'b0;
        end else begin
            s_p1    <= s_nxt;
            q_p1    <= p[OUT_W-1];
            mode_p1 <= mode;
            sync    <= wrap_p0;
        end
    end

    // Stage p2: modulator
    if (ORDER == 1) begin : g_order1
        logic [OUT_W-1:0] err_p2;
        logic [OUT_W:0]   sum1;

        assign sum1 = {1'b0, err_p2} + {1'b0, s_p1};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_p2  <= '0;
                pdm_out <= 1'b0;
            end else if (mode_p1 == MODE_SQUARE) begin
                err_p2  <= '0;
                pdm_out <= q_p1;
            end else if (mode_p1 == MODE_OFF) begin
                err_p2  <= '0;
                pdm_out <= 1'b0;
            end else begin
                err_p2  <= sum1[OUT_W-1:0];
                pdm_out <= sum1[OUT_W];
            end
        end
    end else begin : g_order2
        localparam int INT_W = OUT_W + 4;
        localparam int SUM_W = OUT_W + 6;
        localparam logic signed [SUM_W-1:0] FB_ONE = SUM_W'(1 << OUT_W);
        localparam logic signed [SUM_W-1:0] I_MAX  = SUM_W'((1 << (INT_W - 1)) - 1);
        localparam logic signed [SUM_W-1:0] I_MIN  = SUM_W'(-(1 << (INT_W - 1)));

        // Clamping keeps the loop from wrapping when the input sits at full scale.
        function automatic logic signed [INT_W-1:0] sat_int(input logic signed [SUM_W-1:0] v);
            if (v > I_MAX)
                return I_MAX[INT_W-1:0];
            else if (v < I_MIN)
                return I_MIN[INT_W-1:0];
            return v[INT_W-1:0];
        endfunction

        logic signed [INT_W-1:0] i1_p2, i2_p2, i1_nxt, i2_nxt;
        logic signed [SUM_W-1:0] fb, i1_sum, i2_sum;

        assign fb     = pdm_out ? FB_ONE : '0;
        assign i1_sum = $signed({{(SUM_W - INT_W){i1_p2[INT_W-1]}}, i1_p2})
                      + $signed({{(SUM_W - OUT_W){1'b0}}, s_p1}) - fb;
        assign i1_nxt = sat_int(i1_sum);
        assign i2_sum = $signed({{(SUM_W - INT_W){i2_p2[INT_W-1]}}, i2_p2})
                      + $signed({{(SUM_W - INT_W){i1_nxt[INT_W-1]}}, i1_nxt}) - fb;
        assign i2_nxt = sat_int(i2_sum);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                i1_p2   <= '0;
                i2_p2   <= '0;
                pdm_out <= 1'b0;
            end else if (mode_p1 == MODE_SQUARE) begin
                i1_p2   <= '0;
                i2_p2   <= '0;
                pdm_out <= q_p1;
            end else if (mode_p1 == MODE_OFF) begin
                i1_p2   <= '0;
                i2_p2   <= '0;
                pdm_out <= 1'b0;
            end else begin
                i1_p2   <= i1_nxt;
                i2_p2   <= i2_nxt;
                pdm_out <= ~i2_nxt[INT_W-1];
            end
        end
    end
endmodule

// File: tb/tb_nco_pdm_synth.sv
// Directed bench for nco_pdm_synth: default tile, a 16-bit sawtooth tile and
// a second-order triangle tile run side by side on one clock.
module tb_nco_pdm_synth;
    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [1:0] mode_a, mode_b, mode_c;
    logic       pdm_a, sync_a, pend_a;
    logic       pdm_b, sync_b, pend_b;
    logic       pdm_c, sync_c, pend_c;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;

    nco_pdm_synth_if if_a ();
    nco_pdm_synth_if if_b ();
    nco_pdm_synth_if if_c ();

    nco_pdm_synth dut_a (
        .clk(clk), .rst(rst_a), .ld(if_a), .mode(mode_a),
        .pdm_out(pdm_a), .sync(sync_a), .pending(pend_a)
    );
    nco_pdm_synth #(.ACC_W(16), .FREQ_W(16), .OUT_W(8), .ORDER(1)) dut_b (
        .clk(clk), .rst(rst_b), .ld(if_b), .mode(mode_b),
        .pdm_out(pdm_b), .sync(sync_b), .pending(pend_b)
    );
    nco_pdm_synth #(.ACC_W(24), .FREQ_W(16), .OUT_W(8), .ORDER(2)) dut_c (
        .clk(clk), .rst(rst_c), .ld(if_c), .mode(mode_c),
        .pdm_out(pdm_c), .sync(sync_c), .pending(pend_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic load_a(input logic [7:0] b0, input logic [7:0] b1);
        if_a.ld_valid = 1'b1;
        if_a.ld_data  = b0;
        @(posedge clk); #1;
        if_a.ld_data  = b1;
        @(posedge clk); #1;
        if_a.ld_valid = 1'b0;
    endtask

    task automatic wait_sync_a(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (sync_a) begin
                found = 1;
                break;
            end
        end
        if (found == 0) check(tag, 0, 1);
    endtask

    // Starts on a sync sample; counts samples and ones up to the next sync.
    task automatic period_a(output int len, output int ones);
        len  = 0;
        ones = 0;
        for (int i = 0; i < 20000; i++) begin
            len++;
            ones += int'(pdm_a);
            @(negedge clk);
            if (sync_a) break;
        end
    endtask

    task automatic reset_state_a(input string tag);
        check({tag, "_pdm"},   pdm_a, 0);
        check({tag, "_sync"},  sync_a, 0);
        check({tag, "_pend"},  pend_a, 0);
        check({tag, "_ready"}, if_a.ld_ready, 1);
        check({tag, "_acc"},   dut_a.acc_p0, 0);
    endtask

    initial begin
        int t0, t1, len, ones, cnt, last_rdy, rdy_early;
        logic [31:0] acc0;
        rst_a = 1'b1; mode_a = 2'b01; if_a.ld_valid = 1'b0; if_a.ld_data = 8'h00;
        repeat (3) @(negedge clk);
        reset_state_a("rst0");
        rst_a = 1'b0;

        cnt = 0;
        repeat (300) begin @(negedge clk); cnt += int'(sync_a); end
        check("idle_sync", cnt, 0);

        mode_a = 2'b00;
        @(negedge clk);
        load_a(8'h00, 8'h10);
        cnt = 0;
        repeat (8) begin @(negedge clk); cnt += int'(pend_a); end
        check("pend_le1", (cnt <= 1), 1);
        check("freq_1000", dut_a.freq, 32'h1000);

        wait_sync_a("sync_first");
        period_a(len, ones);
        check("sq_period", len, 4096);
        check("sq_ones", ones, 2048);

        t0 = cyc;
        repeat (1000) @(negedge clk);
        load_a(8'h00, 8'h20);
        check("ready_low", if_a.ld_ready, 0);
        last_rdy = 0; rdy_early = 0; t1 = -100000;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (sync_a) begin t1 = cyc; break; end
            rdy_early += last_rdy;
            last_rdy = int'(if_a.ld_ready);
        end
        check("phase_interval", t1 - t0, 4096);
        check("ready_early", rdy_early, 0);
        check("commit_at_wrap", last_rdy, 1);
        period_a(len, ones);
        check("p2k_period", len, 2048);
        check("p2k_ones", ones, 1024);

        repeat (100) @(negedge clk);
        load_a(8'h00, 8'h40);
        if_a.ld_valid = 1'b1;
        if_a.ld_data  = 8'hAB;
        cnt = 0;
        repeat (20) begin @(negedge clk); cnt += int'(if_a.ld_ready); end
        check("bp_ready", cnt, 0);
        check("bp_bytecnt", dut_a.byte_cnt, 0);
        check("bp_pending", pend_a, 1);
        mode_a = 2'b11;
        if_a.ld_valid = 1'b0;
        @(posedge clk); #1;
        check("off_commit", pend_a, 0);
        check("off_freq", dut_a.freq, 32'h4000);
        acc0 = dut_a.acc_p0;
        repeat (3) @(negedge clk);
        ones = 0; cnt = 0;
        repeat (40) begin
            @(negedge clk);
            ones += int'(pdm_a);
            cnt  += int'(sync_a);
        end
        check("off_pdm", ones, 0);
        check("off_sync", cnt, 0);
        check("off_acc_frozen", dut_a.acc_p0, acc0);

        mode_a = 2'b00;
        wait_sync_a("sync_4000");
        period_a(len, ones);
        check("p1k_period", len, 1024);
        check("p1k_ones", ones, 512);

        if_a.ld_valid = 1'b1;
        if_a.ld_data  = 8'h55;
        @(posedge clk); #1;
        if_a.ld_valid = 1'b0;
        check("midload_cnt", dut_a.byte_cnt, 1);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        reset_state_a("rst1");
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        check("rst1_bytecnt", dut_a.byte_cnt, 0);
        check("rst1_shadow", dut_a.shadow, 0);
        check("rst1_freq", dut_a.freq, 0);
        mode_a = 2'b01;
        cnt = 0;
        repeat (300) begin @(negedge clk); cnt += int'(sync_a); end
        check("rst1_idle_sync", cnt, 0);
        done_a = 1'b1;
    end

    // Sample j after the completing byte reflects edge j; pdm at edge m uses acc = (m-3)*freq.
    initial begin
        int zeros_win, ones_40;
        rst_b = 1'b1; mode_b = 2'b01; if_b.ld_valid = 1'b0; if_b.ld_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        if_b.ld_valid = 1'b1; if_b.ld_data = 8'h01;
        @(posedge clk); #1;
        if_b.ld_data = 8'h00;
        @(posedge clk); #1;
        if_b.ld_valid = 1'b0;
        zeros_win = 0; ones_40 = 0;
        for (int j = 0; j <= 16700; j++) begin
            @(negedge clk);
            if (j < 256) zeros_win += int'(pdm_b);
            if (j >= 16387 && j <= 16642) ones_40 += int'(pdm_b);
        end
        check("saw_p00_ones", zeros_win, 0);
        check("saw_p40_ones", ones_40, 64);
        done_b = 1'b1;
    end

    initial begin
        int ones_all, ones_top;
        rst_c = 1'b1; mode_c = 2'b10; if_c.ld_valid = 1'b0; if_c.ld_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_c = 1'b0;
        @(negedge clk);
        if_c.ld_valid = 1'b1; if_c.ld_data = 8'h00;
        @(posedge clk); #1;
        if_c.ld_data = 8'h01;
        @(posedge clk); #1;
        if_c.ld_valid = 1'b0;
        ones_all = 0; ones_top = 0;
        for (int j = 0; j <= 65538; j++) begin
            @(negedge clk);
            if (j >= 3) ones_all += int'(pdm_c);
            if (j >= 32771 && j <= 33026) ones_top += int'(pdm_c);
        end
        check("tri2_half_density", (ones_all >= 32113 && ones_all <= 33423), 1);
        check("tri2_top_window", (ones_top >= 250), 1);
        done_c = 1'b1;
    end

    initial begin
        wait (done_a && done_b && done_c);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: bench did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
